// File: rtl/spu_issue_queue_pkg.sv
// ---------------------------------------------------------------------------
// spu_issue_queue_pkg
// Shared types for the special-purpose-op issue queue and its neighbours
// (dispatch, SPU, commit).
//   - PHY_REG_W / ROB_W : physical tag and ROB index widths
//   - spu_op_t          : special-purpose operation encoding
//   - decoded_inst_t    : decoded op as delivered by dispatch
//   - spu_iq_entry_t    : one queue slot (valid, op, ROB slot, tags, ready bits)
//   - issue_to_execute_bus_t : payload handed to the SPU
//   - is_spu_serializing(): ops that must wait to be oldest in the ROB
// ---------------------------------------------------------------------------
package spu_issue_queue_pkg;

    localparam int PHY_REG_W = 6;
    localparam int ROB_W     = 4;

    typedef logic [PHY_REG_W-1:0] reg_addr_t;
    typedef logic [ROB_W-1:0]     rob_idx_t;

    typedef enum logic [4:0] {
        SPU_OP_NONE  = 5'd0,
        SPU_OP_MFC0  = 5'd1,
        SPU_OP_MTC0  = 5'd2,
        SPU_OP_ERET  = 5'd3,
        SPU_OP_TLBP  = 5'd4,
        SPU_OP_TLBR  = 5'd5,
        SPU_OP_TLBWI = 5'd6,
        SPU_OP_CACHE = 5'd7,
        SPU_OP_TEQ   = 5'd8,
        SPU_OP_TNE   = 5'd9,
        SPU_OP_TGE   = 5'd10,
        SPU_OP_TLT   = 5'd11
    } spu_op_t;

    typedef struct packed {
        spu_op_t     operation;
        logic [15:0] imm;
    } decoded_inst_t;

    typedef struct packed {
        logic          valid;
        decoded_inst_t inst;
        rob_idx_t      rob_entry_num;
        reg_addr_t     phy_dest;
        reg_addr_t     src1_tag;
        reg_addr_t     src2_tag;
        logic          src1_ready;
        logic          src2_ready;
    } spu_iq_entry_t;

    typedef struct packed {
        decoded_inst_t inst;
        rob_idx_t      rob_entry_num;
        reg_addr_t     phy_dest;
        logic [31:0]   src1_value;
        logic [31:0]   src2_value;
    } issue_to_execute_bus_t;

    // CP0/TLB/cache ops touch architectural state that younger ops may
    // depend on, so they only run once everything older has committed.
    // Traps only read GPRs and are left out.
    function automatic logic is_spu_serializing(input spu_op_t op);
        case (op)
            SPU_OP_MFC0, SPU_OP_MTC0, SPU_OP_ERET,
            SPU_OP_TLBP, SPU_OP_TLBR, SPU_OP_TLBWI,
            SPU_OP_CACHE: is_spu_serializing = 1'b1;
            default:      is_spu_serializing = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spu_issue_queue_wakeup_match.sv
// ---------------------------------------------------------------------------
// spu_iq_wakeup_match
// Compares one source tag against every writeback wakeup port.
//   tag      in  source tag under test
//   wb_valid in  per-port wakeup valid
//   wb_tag   in  per-port wakeup tags, port i at [i*PHY_REG_W +: PHY_REG_W]
//   hit      out tag is (or becomes) available this cycle
// Tag 0 is the hardwired zero register and always reports a hit.
// ---------------------------------------------------------------------------
module spu_iq_wakeup_match
    import spu_issue_queue_pkg::*;
#(
    parameter int WB_PORTS = 4
) (
    input  reg_addr_t                     tag,
    input  logic [WB_PORTS-1:0]           wb_valid,
    input  logic [WB_PORTS*PHY_REG_W-1:0] wb_tag,
    output logic                          hit
);

    logic [WB_PORTS-1:0] port_hit;

    generate
        for (genvar gi = 0; gi < WB_PORTS; gi++) begin : g_port
            assign port_hit[gi] = wb_valid[gi] &&
                                  (wb_tag[gi*PHY_REG_W +: PHY_REG_W] == tag);
        end
    endgenerate

    assign hit = (tag == '0) || (|port_hit);

endmodule

// File: rtl/spu_issue_queue.sv
// ---------------------------------------------------------------------------
// spu_issue_queue
// In-order issue queue for special-purpose ops (CP0 moves, ERET, TLB ops,
// CACHE, traps) between rename/dispatch and the SPU. Tracks operand
// readiness from writeback wakeups and reads the RF for the head entry.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   flush                 synchronous clear of the whole queue
//   enq_*                 dispatch side (valid/ready, op, ROB slot, tags)
//   wb_valid, wb_tag      writeback wakeup broadcast
//   rob_head_num          oldest uncommitted ROB entry
//   rf_raddr1/2, rf_rdata1/2  physical RF read for the head op
//   issue_valid, spu_ready, issue_inst  SPU side
//
// Configuration
//   SPU_IQ_SERIALIZE_ALL_EN : when defined every op (traps included) waits
//   for the ROB head before issuing; otherwise only is_spu_serializing ops.
// ---------------------------------------------------------------------------
module spu_issue_queue
    import spu_issue_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int WB_PORTS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,

    input  logic                          enq_valid,
    output logic                          enq_ready,
    input  decoded_inst_t                 enq_inst,
    input  rob_idx_t                      enq_rob_entry_num,
    input  reg_addr_t                     enq_phy_dest,
    input  reg_addr_t                     enq_src1_tag,
    input  reg_addr_t                     enq_src2_tag,
    input  logic                          enq_src1_ready,
    input  logic                          enq_src2_ready,

    input  logic [WB_PORTS-1:0]           wb_valid,
    input  logic [WB_PORTS*PHY_REG_W-1:0] wb_tag,

    input  rob_idx_t                      rob_head_num,

    output reg_addr_t                     rf_raddr1,
    output reg_addr_t                     rf_raddr2,
    input  logic [31:0]                   rf_rdata1,
    input  logic [31:0]                   rf_rdata2,

    output logic                          issue_valid,
    input  logic                          spu_ready,
    output issue_to_execute_bus_t         issue_inst
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    spu_iq_entry_t    entries_q [DEPTH];
    spu_iq_entry_t    entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0] src1_hit;
    logic [DEPTH-1:0] src2_hit;
    logic             enq_src1_hit;
    logic             enq_src2_hit;

    spu_iq_entry_t    head_entry;
    spu_iq_entry_t    new_entry;
    logic             needs_rob_head;
    logic             enq_fire;
    logic             deq_fire;

    // Wakeup comparators: one pair per stored entry plus one pair for the
    // incoming op so a same-cycle broadcast is not lost at enqueue.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_match
            spu_iq_wakeup_match #(.WB_PORTS(WB_PORTS)) u_src1 (
                .tag      (entries_q[gi].src1_tag),
                .wb_valid (wb_valid),
                .wb_tag   (wb_tag),
                .hit      (src1_hit[gi])
            );
            spu_iq_wakeup_match #(.WB_PORTS(WB_PORTS)) u_src2 (
                .tag      (entries_q[gi].src2_tag),
                .wb_valid (wb_valid),
                .wb_tag   (wb_tag),
                .hit      (src2_hit[gi])
            );
        end
    endgenerate

    spu_iq_wakeup_match #(.WB_PORTS(WB_PORTS)) u_enq_src1 (
        .tag      (enq_src1_tag),
        .wb_valid (wb_valid),
        .wb_tag   (wb_tag),
        .hit      (enq_src1_hit)
    );

    spu_iq_wakeup_match #(.WB_PORTS(WB_PORTS)) u_enq_src2 (
        .tag      (enq_src2_tag),
        .wb_valid (wb_valid),
        .wb_tag   (wb_tag),
        .hit      (enq_src2_hit)
    );

    assign head_entry = entries_q[head_q];

`ifdef SPU_IQ_SERIALIZE_ALL_EN
    assign needs_rob_head = 1'b1;
`else
    assign needs_rob_head = is_spu_serializing(head_entry.inst.operation);
`endif

    // Issue uses registered state only, keeping spu_ready and wakeups off
    // the issue_valid / enq_ready paths.
    assign issue_valid = head_entry.valid &&
                         head_entry.src1_ready && head_entry.src2_ready &&
                         (!needs_rob_head ||
                          (head_entry.rob_entry_num == rob_head_num));

    assign enq_ready = (count_q != FULL_CNT);
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = issue_valid && spu_ready;

    assign rf_raddr1 = head_entry.src1_tag;
    assign rf_raddr2 = head_entry.src2_tag;

    always_comb begin
        issue_inst = '0;
        if (head_entry.valid) begin
            issue_inst.inst          = head_entry.inst;
            issue_inst.rob_entry_num = head_entry.rob_entry_num;
            issue_inst.phy_dest      = head_entry.phy_dest;
            issue_inst.src1_value    = rf_rdata1;
            issue_inst.src2_value    = rf_rdata2;
        end
    end

    always_comb begin
        new_entry               = '0;
        new_entry.valid         = 1'b1;
        new_entry.inst          = enq_inst;
        new_entry.rob_entry_num = enq_rob_entry_num;
        new_entry.phy_dest      = enq_phy_dest;
        new_entry.src1_tag      = enq_src1_tag;
        new_entry.src2_tag      = enq_src2_tag;
        new_entry.src1_ready    = enq_src1_ready || enq_src1_hit;
        new_entry.src2_ready    = enq_src2_ready || enq_src2_hit;
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        // Ready bits are sticky until the entry leaves the queue.
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid) begin
                if (src1_hit[i]) entries_d[i].src1_ready = 1'b1;
                if (src2_hit[i]) entries_d[i].src2_ready = 1'b1;
            end
        end

        // Head and tail can only coincide when empty (no deq) or full
        // (no enq), so these two writes never target the same slot.
        if (deq_fire) begin
            entries_d[head_q] = '0;
            head_d            = head_q + PTR_W'(1);
        end
        if (enq_fire) begin
            entries_d[tail_q] = new_entry;
            tail_d            = tail_q + PTR_W'(1);
        end

        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Flush overrides any enqueue/dequeue in the same cycle.
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_spu_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_spu_issue_queue
// Directed testbench for spu_issue_queue: reset, operand wakeup, ROB-head
// serialization, full/wrap behaviour, flush, and trap issue with and
// without SPU_IQ_SERIALIZE_ALL_EN.
// ---------------------------------------------------------------------------
module tb_spu_issue_queue;
    import spu_issue_queue_pkg::*;

    localparam int DEPTH    = 4;
    localparam int WB_PORTS = 4;

    logic                          clk;
    logic                          reset;
    logic                          flush;
    logic                          enq_valid;
    logic                          enq_ready;
    decoded_inst_t                 enq_inst;
    rob_idx_t                      enq_rob_entry_num;
    reg_addr_t                     enq_phy_dest;
    reg_addr_t                     enq_src1_tag;
    reg_addr_t                     enq_src2_tag;
    logic                          enq_src1_ready;
    logic                          enq_src2_ready;
    logic [WB_PORTS-1:0]           wb_valid;
    logic [WB_PORTS*PHY_REG_W-1:0] wb_tag;
    rob_idx_t                      rob_head_num;
    reg_addr_t                     rf_raddr1;
    reg_addr_t                     rf_raddr2;
    logic [31:0]                   rf_rdata1;
    logic [31:0]                   rf_rdata2;
    logic                          issue_valid;
    logic                          spu_ready;
    issue_to_execute_bus_t         issue_inst;

    int n_checks;
    int n_errors;
    logic exp_trap_iv;

    spu_issue_queue #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .enq_valid         (enq_valid),
        .enq_ready         (enq_ready),
        .enq_inst          (enq_inst),
        .enq_rob_entry_num (enq_rob_entry_num),
        .enq_phy_dest      (enq_phy_dest),
        .enq_src1_tag      (enq_src1_tag),
        .enq_src2_tag      (enq_src2_tag),
        .enq_src1_ready    (enq_src1_ready),
        .enq_src2_ready    (enq_src2_ready),
        .wb_valid          (wb_valid),
        .wb_tag            (wb_tag),
        .rob_head_num      (rob_head_num),
        .rf_raddr1         (rf_raddr1),
        .rf_raddr2         (rf_raddr2),
        .rf_rdata1         (rf_rdata1),
        .rf_rdata2         (rf_rdata2),
        .issue_valid       (issue_valid),
        .spu_ready         (spu_ready),
        .issue_inst        (issue_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_enq(input spu_op_t op, input int rob, input int dest,
                           input int t1, input logic r1,
                           input int t2, input logic r2);
        enq_inst.operation = op;
        enq_inst.imm       = 16'(rob * 16'h0101);
        enq_rob_entry_num  = ROB_W'(rob);
        enq_phy_dest       = PHY_REG_W'(dest);
        enq_src1_tag       = PHY_REG_W'(t1);
        enq_src1_ready     = r1;
        enq_src2_tag       = PHY_REG_W'(t2);
        enq_src2_ready     = r2;
    endtask

    task automatic enq(input spu_op_t op, input int rob, input int dest,
                       input int t1, input logic r1,
                       input int t2, input logic r2);
        set_enq(op, rob, dest, t1, r1, t2, r2);
        enq_valid = 1'b1;
        $display("enq op=%s rob=%0d dest=%0d src1=%0d/%0b src2=%0d/%0b ready=%0b",
                 op.name(), rob, dest, t1, r1, t2, r2, enq_ready);
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic deq();
        $display("deq rob=%0d issue_valid=%0b", issue_inst.rob_entry_num, issue_valid);
        spu_ready = 1'b1;
        tick();
        spu_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        flush     = 1'b0;
        enq_valid = 1'b0;
        set_enq(SPU_OP_NONE, 0, 0, 0, 1'b0, 0, 1'b0);
        wb_valid     = '0;
        wb_tag       = '0;
        rob_head_num = '0;
        rf_rdata1    = 32'hAAAA_0001;
        rf_rdata2    = 32'hBBBB_0002;
        spu_ready    = 1'b0;
`ifdef SPU_IQ_SERIALIZE_ALL_EN
        exp_trap_iv = 1'b0;
`else
        exp_trap_iv = 1'b1;
`endif

        // Reset state
        do_reset();
        check("rst_enq_ready", 64'(enq_ready), 64'd1);
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_bus_zero", 64'(issue_inst == '0), 64'd1);

        // 1: MFC0, operands ready, ROB head matches -> issues next cycle
        rob_head_num = 4'd2;
        enq(SPU_OP_MFC0, 2, 10, 1, 1'b1, 2, 1'b1);
        check("t1_issue_valid", 64'(issue_valid), 64'd1);
        check("t1_rob", 64'(issue_inst.rob_entry_num), 64'd2);
        check("t1_dest", 64'(issue_inst.phy_dest), 64'd10);
        check("t1_raddr1", 64'(rf_raddr1), 64'd1);
        check("t1_src1_value", 64'(issue_inst.src1_value), 64'hAAAA_0001);
        deq();
        check("t1_empty_iv", 64'(issue_valid), 64'd0);
        check("t1_empty_bus", 64'(issue_inst == '0), 64'd1);

        // 2: MTC0 waiting on tag 7 (src1 is tag 0 -> always ready)
        rob_head_num = 4'd3;
        enq(SPU_OP_MTC0, 3, 11, 0, 1'b0, 7, 1'b0);
        check("t2_wait_iv", 64'(issue_valid), 64'd0);
        check("t2_raddr2", 64'(rf_raddr2), 64'd7);
        wb_valid = 4'b0100;
        wb_tag   = {6'd0, 6'd7, 6'd0, 6'd0};
        #1;
        check("t2_wake_same_cycle_iv", 64'(issue_valid), 64'd0);
        tick();
        wb_valid = '0;
        wb_tag   = '0;
        check("t2_wake_next_iv", 64'(issue_valid), 64'd1);
        rf_rdata2 = 32'h1234_5678;
        #1;
        check("t2_src2_value", 64'(issue_inst.src2_value), 64'h1234_5678);
        check("t2_raddr1_zero", 64'(rf_raddr1), 64'd0);
        deq();
        check("t2_empty_iv", 64'(issue_valid), 64'd0);

        // 2b: wakeup arriving in the enqueue cycle is captured
        wb_valid = 4'b0001;
        wb_tag   = {6'd0, 6'd0, 6'd0, 6'd9};
        enq(SPU_OP_MFC0, 3, 12, 9, 1'b0, 4, 1'b1);
        wb_valid = '0;
        wb_tag   = '0;
        check("t2b_enq_wake_iv", 64'(issue_valid), 64'd1);
        deq();

        // 3: TLBWI waits for ROB head; younger ready MFC0 stays behind it
        rob_head_num = 4'd3;
        enq(SPU_OP_TLBWI, 5, 1, 1, 1'b1, 2, 1'b1);
        enq(SPU_OP_MFC0, 6, 13, 1, 1'b1, 2, 1'b1);
        check("t3_stall_iv", 64'(issue_valid), 64'd0);
        check("t3_head_rob", 64'(issue_inst.rob_entry_num), 64'd5);
        check("t3_head_op", 64'(issue_inst.inst.operation), 64'(SPU_OP_TLBWI));
        rob_head_num = 4'd5;
        #1;
        check("t3_go_iv", 64'(issue_valid), 64'd1);
        deq();
        check("t3_younger_rob", 64'(issue_inst.rob_entry_num), 64'd6);
        check("t3_younger_wait_iv", 64'(issue_valid), 64'd0);
        rob_head_num = 4'd6;
        #1;
        check("t3_younger_go_iv", 64'(issue_valid), 64'd1);
        deq();
        check("t3_empty_bus", 64'(issue_inst == '0), 64'd1);

        // 4: fill, refused enq during deq at full, tail wrap
        do_reset();
        rob_head_num = 4'd0;
        for (int r = 8; r < 12; r++) begin
            enq(SPU_OP_MFC0, r, r, 1, 1'b1, 2, 1'b1);
        end
        check("t4_full_ready", 64'(enq_ready), 64'd0);
        check("t4_head_rob", 64'(issue_inst.rob_entry_num), 64'd8);
        rob_head_num = 4'd8;
        set_enq(SPU_OP_MFC0, 13, 13, 1, 1'b1, 2, 1'b1);
        enq_valid = 1'b1;
        spu_ready = 1'b1;
        #1;
        check("t4_full_deq_ready", 64'(enq_ready), 64'd0);
        check("t4_full_deq_iv", 64'(issue_valid), 64'd1);
        tick();
        enq_valid = 1'b0;
        spu_ready = 1'b0;
        check("t4_after_ready", 64'(enq_ready), 64'd1);
        check("t4_after_head", 64'(issue_inst.rob_entry_num), 64'd9);
        enq(SPU_OP_MFC0, 12, 12, 1, 1'b1, 2, 1'b1);
        check("t4_refull_ready", 64'(enq_ready), 64'd0);
        for (int r = 9; r < 13; r++) begin
            rob_head_num = ROB_W'(r);
            #1;
            check("t4_drain_iv", 64'(issue_valid), 64'd1);
            check("t4_drain_rob", 64'(issue_inst.rob_entry_num), 64'(r));
            deq();
        end
        check("t4_drained_iv", 64'(issue_valid), 64'd0);
        check("t4_drained_ready", 64'(enq_ready), 64'd1);

        // 5: flush with three entries and a simultaneous enqueue
        rob_head_num = 4'd0;
        enq(SPU_OP_MFC0, 1, 1, 1, 1'b1, 2, 1'b1);
        enq(SPU_OP_MFC0, 2, 2, 1, 1'b1, 2, 1'b1);
        enq(SPU_OP_MFC0, 3, 3, 1, 1'b1, 2, 1'b1);
        set_enq(SPU_OP_MFC0, 7, 7, 1, 1'b1, 2, 1'b1);
        rob_head_num = 4'd7;
        flush     = 1'b1;
        enq_valid = 1'b1;
        spu_ready = 1'b1;
        $display("flush with enq rob=7");
        tick();
        flush     = 1'b0;
        enq_valid = 1'b0;
        spu_ready = 1'b0;
        check("t5_iv", 64'(issue_valid), 64'd0);
        check("t5_ready", 64'(enq_ready), 64'd1);
        check("t5_bus_zero", 64'(issue_inst == '0), 64'd1);

        // 6: trap op with ROB-head mismatch; spu_ready low holds the bus
        rob_head_num = 4'd1;
        enq(SPU_OP_TEQ, 4, 20, 3, 1'b1, 5, 1'b1);
        for (int c = 0; c < 2; c++) begin
            check("t6_trap_iv", 64'(issue_valid), 64'(exp_trap_iv));
            check("t6_trap_rob", 64'(issue_inst.rob_entry_num), 64'd4);
            check("t6_trap_dest", 64'(issue_inst.phy_dest), 64'd20);
            check("t6_trap_op", 64'(issue_inst.inst.operation), 64'(SPU_OP_TEQ));
            tick();
        end
        rob_head_num = 4'd4;
        #1;
        check("t6_head_iv", 64'(issue_valid), 64'd1);
        deq();
        check("t6_empty_iv", 64'(issue_valid), 64'd0);
        check("t6_empty_ready", 64'(enq_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
